// File: rtl/oversample_cal_pkg.sv
// Shared types and constants for the oversampling delay calibration block.
// Holds the FSM encoding and the default widths used by all cal modules.
package oversample_cal_pkg;

   localparam int TAP_W     = 5;
   localparam int CNT_W_DEF = 11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_RDY,
      ST_LOAD,
      ST_SETTLE,
      ST_MEASURE,
      ST_COMPARE,
      ST_APPLY,
      ST_DONE
   } cal_state_e;

endpackage

// File: rtl/edge_counter_sat.sv
// Counts cycles where the two monitored adjacent samples disagree.
// Saturates at all-ones so long windows never wrap to a small count.
module edge_counter_sat
   import oversample_cal_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             aresetn,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [1:0]       pair_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             edge_hit;

   assign edge_hit = pair_i[1] ^ pair_i[0];

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && edge_hit && (cnt_q != '1))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/oversample_delay_cal.sv
// IDELAYE2 tap sweep: measures edge density per tap on one sample pair
// and loads the quietest tap back into the delay line.
module oversample_delay_cal
   import oversample_cal_pkg::*;
#(
   parameter int TAP_MAX       = 31,
   parameter int SETTLE_CYCLES = 8,
   parameter int WINDOW_CYCLES = 1024,
   parameter int CNT_W         = CNT_W_DEF,
   parameter int CHK_HI        = 4,
   parameter int CHK_LO        = 3,
   parameter int ERR_THRESH    = 64
) (
   input  logic             clk,
   input  logic             aresetn,
   input  logic             start,
   input  logic             idelayctrl_ready,
   input  logic [7:0]       sample_window,
   output logic             delay_ld,
   output logic [TAP_W-1:0] delay_cntvalue,
   output logic             busy,
   output logic             done,
   output logic [TAP_W-1:0] best_tap,
   output logic [CNT_W-1:0] best_count,
   output logic             cal_err
);

   localparam int SET_W = $clog2(SETTLE_CYCLES) + 1;
   localparam int WIN_W = $clog2(WINDOW_CYCLES) + 1;

   cal_state_e       state_q;
   logic             rdy_meta_q;
   logic             rdy_s_q;
   logic [TAP_W-1:0] tap_q;
   logic [TAP_W-1:0] tap_d;
   logic [SET_W-1:0] settle_q;
   logic [WIN_W-1:0] win_q;
   logic             ld_q;
   logic [TAP_W-1:0] cntval_q;
   logic             busy_q;
   logic             done_q;
   logic [TAP_W-1:0] best_tap_q;
   logic [CNT_W-1:0] best_cnt_q;
   logic             cal_err_q;

   logic [CNT_W-1:0] edge_cnt;
   logic             better;
   logic             abort;

   edge_counter_sat #(
      .CNT_W (CNT_W)
   ) u_edge_cnt (
      .clk     (clk),
      .aresetn (aresetn),
      .clr_i   (state_q == ST_SETTLE),
      .en_i    (state_q == ST_MEASURE),
      .pair_i  ({sample_window[CHK_HI], sample_window[CHK_LO]}),
      .cnt_o   (edge_cnt)
   );

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         rdy_meta_q <= 1'b0;
         rdy_s_q    <= 1'b0;
      end else begin
         rdy_meta_q <= idelayctrl_ready;
         rdy_s_q    <= rdy_meta_q;
      end
   end

   assign better = edge_cnt < best_cnt_q;
   assign tap_d  = tap_q + TAP_W'(1);
   // Losing RDY anywhere in the per-tap loop invalidates the whole sweep.
   assign abort  = !rdy_s_q && (state_q inside
                   {ST_LOAD, ST_SETTLE, ST_MEASURE, ST_COMPARE});

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q    <= ST_IDLE;
         tap_q      <= '0;
         settle_q   <= '0;
         win_q      <= '0;
         ld_q       <= 1'b0;
         cntval_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         best_tap_q <= '0;
         best_cnt_q <= '1;
         cal_err_q  <= 1'b0;
      end else begin
         ld_q <= 1'b0;
         if (abort) begin
            state_q    <= ST_WAIT_RDY;
            tap_q      <= '0;
            best_cnt_q <= '1;
         end else begin
            unique case (state_q)
               ST_IDLE, ST_DONE: begin
                  if (start) begin
                     state_q    <= ST_WAIT_RDY;
                     busy_q     <= 1'b1;
                     done_q     <= 1'b0;
                     cal_err_q  <= 1'b0;
                     best_cnt_q <= '1;
                     tap_q      <= '0;
                  end
               end
               ST_WAIT_RDY: begin
                  if (rdy_s_q) begin
                     state_q  <= ST_LOAD;
                     ld_q     <= 1'b1;
                     cntval_q <= tap_q;
                  end
               end
               ST_LOAD: begin
                  state_q  <= ST_SETTLE;
                  settle_q <= '0;
               end
               ST_SETTLE: begin
                  if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
                     state_q <= ST_MEASURE;
                     win_q   <= '0;
                  end else begin
                     settle_q <= settle_q + SET_W'(1);
                  end
               end
               ST_MEASURE: begin
                  if (win_q == WIN_W'(WINDOW_CYCLES - 1))
                     state_q <= ST_COMPARE;
                  else
                     win_q <= win_q + WIN_W'(1);
               end
               ST_COMPARE: begin
                  if (better) begin
                     best_tap_q <= tap_q;
                     best_cnt_q <= edge_cnt;
                  end
                  ld_q <= 1'b1;
                  if (tap_q == TAP_W'(TAP_MAX)) begin
                     state_q  <= ST_APPLY;
                     cntval_q <= better ? tap_q : best_tap_q;
                  end else begin
                     state_q  <= ST_LOAD;
                     tap_q    <= tap_d;
                     cntval_q <= tap_d;
                  end
               end
               ST_APPLY: begin
                  state_q   <= ST_DONE;
                  cal_err_q <= best_cnt_q > CNT_W'(ERR_THRESH);
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign delay_ld       = ld_q;
   assign delay_cntvalue = cntval_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign best_tap       = best_tap_q;
   assign best_count     = best_cnt_q;
   assign cal_err        = cal_err_q;

endmodule

// File: tb/tb_oversample_delay_cal.sv
// Scoreboard bench for oversample_delay_cal: LD taps and final results
// are queued at start and compared as the DUT strobes / completes.
module tb_oversample_delay_cal;

   localparam int TM  = 31;
   localparam int SET = 4;
   localparam int WIN = 16;
   localparam int CW  = 11;
   localparam int ETH = 8;
   localparam int LAT = 2 + (TM + 1) * (1 + SET + WIN + 1) + 1;

   typedef struct {
      logic [4:0]    tap;
      logic [CW-1:0] cnt;
      logic          err;
   } res_t;

   logic          clk = 1'b0;
   logic          aresetn;
   logic          start;
   logic          rdy;
   logic [7:0]    sw;
   logic          delay_ld;
   logic [4:0]    delay_cntvalue;
   logic          busy;
   logic          done;
   logic [4:0]    best_tap;
   logic [CW-1:0] best_count;
   logic          cal_err;

   int   n_chk = 0;
   int   n_err = 0;
   int   mode  = 0;
   int   cyc   = 0;
   logic [4:0] itap = '0;
   logic       done_d = 1'b0;
   logic [4:0] ldq[$];
   res_t       rq[$];
   logic [4:0] mon_e;
   res_t       mon_r;
   int         lat;

   oversample_delay_cal #(
      .TAP_MAX       (TM),
      .SETTLE_CYCLES (SET),
      .WINDOW_CYCLES (WIN),
      .CNT_W         (CW),
      .CHK_HI        (4),
      .CHK_LO        (3),
      .ERR_THRESH    (ETH)
   ) dut (
      .clk              (clk),
      .aresetn          (aresetn),
      .start            (start),
      .idelayctrl_ready (rdy),
      .sample_window    (sw),
      .delay_ld         (delay_ld),
      .delay_cntvalue   (delay_cntvalue),
      .busy             (busy),
      .done             (done),
      .best_tap         (best_tap),
      .best_count       (best_count),
      .cal_err          (cal_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Delay-line model: tap latched on LD, window pattern per mode.
   always @(negedge clk)
      if (delay_ld) itap = delay_cntvalue;

   always @(posedge clk) begin
      logic [7:0] w;
      logic       d;
      #1;
      cyc++;
      w = 8'($urandom);
      case (mode)
         0:       d = !(itap >= 12 && itap <= 15);
         1:       d = (cyc % 16) < 5;
         default: d = 1'b1;
      endcase
      w[3] = w[4] ^ d;
      sw = w;
   end

   always @(negedge clk) begin
      if (aresetn) begin
         if (delay_ld) begin
            if (ldq.size() == 0) begin
               chk("ld_unexp", 32'(delay_ld), 32'd0);
            end else begin
               mon_e = ldq.pop_front();
               chk("ld_tap", 32'(delay_cntvalue), 32'(mon_e));
            end
         end
         if (done && !done_d) begin
            if (rq.size() == 0) begin
               chk("done_unexp", 32'(done), 32'd0);
            end else begin
               mon_r = rq.pop_front();
               chk("best_tap", 32'(best_tap), 32'(mon_r.tap));
               chk("best_cnt", 32'(best_count), 32'(mon_r.cnt));
               chk("cal_err", 32'(cal_err), 32'(mon_r.err));
               chk("busy_done", 32'(busy), 32'd0);
            end
         end
      end
      done_d = done;
   end

   task automatic push_sweep(input logic [4:0] bt, input logic [CW-1:0] bc,
                             input logic be);
      res_t r;
      for (int t = 0; t <= TM; t++) ldq.push_back(5'(t));
      ldq.push_back(bt);
      r.tap = bt;
      r.cnt = bc;
      r.err = be;
      rq.push_back(r);
   endtask

   task automatic pulse_start;
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(output int l);
      l = 1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (done) break;
         @(posedge clk);
         l++;
      end
      if (!done) chk("done_timeout", 32'(done), 32'd1);
   endtask

   task automatic wait_ld(input logic [4:0] t);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 3000 && !hit; i++) begin
         @(negedge clk);
         hit = delay_ld && (delay_cntvalue == t);
      end
      if (!hit) chk("ld_timeout", 32'(delay_cntvalue), 32'(t));
   endtask

   initial begin
      aresetn = 1'b0;
      start   = 1'b0;
      rdy     = 1'b1;
      sw      = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ld", 32'(delay_ld), 32'd0);
      chk("rst_cv", 32'(delay_cntvalue), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_btap", 32'(best_tap), 32'd0);
      chk("rst_bcnt", 32'(best_count), 32'h7ff);
      chk("rst_err", 32'(cal_err), 32'd0);
      aresetn = 1'b1;
      repeat (4) @(posedge clk);

      // Quiet taps 12..15, everything else toggles every cycle.
      mode = 0;
      push_sweep(5'd12, '0, 1'b0);
      pulse_start();
      chk("s1_busy", 32'(busy), 32'd1);
      wait_done(lat);
      chk("s1_latency", 32'(lat), 32'(LAT));

      // Equal edge density everywhere: lowest tap must win.
      mode = 1;
      push_sweep(5'd0, CW'(5), 1'b0);
      pulse_start();
      wait_done(lat);

      mode = 2;
      push_sweep(5'd0, CW'(16), 1'b1);
      pulse_start();
      wait_done(lat);

      // RDY drop in MEASURE at tap 20 restarts from tap 0.
      mode = 0;
      for (int t = 0; t <= 20; t++) ldq.push_back(5'(t));
      push_sweep(5'd12, '0, 1'b0);
      pulse_start();
      wait_ld(5'd20);
      repeat (8) @(posedge clk);
      #1 rdy = 1'b0;
      repeat (3) @(posedge clk);
      #1 rdy = 1'b1;
      wait_done(lat);

      // Start while busy is ignored; start from DONE re-sweeps.
      push_sweep(5'd12, '0, 1'b0);
      pulse_start();
      repeat (100) @(posedge clk);
      pulse_start();
      wait_done(lat);
      push_sweep(5'd12, '0, 1'b0);
      pulse_start();
      chk("restart_done", 32'(done), 32'd0);
      chk("restart_busy", 32'(busy), 32'd1);
      wait_done(lat);

      // Async reset mid-SETTLE at tap 1.
      ldq.push_back(5'd0);
      ldq.push_back(5'd1);
      pulse_start();
      wait_ld(5'd1);
      @(posedge clk);
      @(posedge clk);
      #3 aresetn = 1'b0;
      #1;
      chk("ar_ld", 32'(delay_ld), 32'd0);
      chk("ar_cv", 32'(delay_cntvalue), 32'd0);
      chk("ar_busy", 32'(busy), 32'd0);
      chk("ar_done", 32'(done), 32'd0);
      chk("ar_btap", 32'(best_tap), 32'd0);
      chk("ar_bcnt", 32'(best_count), 32'h7ff);
      chk("ar_err", 32'(cal_err), 32'd0);
      repeat (2) @(posedge clk);
      #1 aresetn = 1'b1;
      repeat (60) @(posedge clk);
      #1;
      chk("post_busy", 32'(busy), 32'd0);
      chk("post_cv", 32'(delay_cntvalue), 32'd0);
      chk("ldq_left", 32'(ldq.size()), 32'd0);
      chk("rq_left", 32'(rq.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/oversample_delay_cal.md
Name: oversample_delay_cal

Overview:
Calibration controller for the 4x-oversampling front end. It drives the shared IDELAYE2 tap value in VAR_LOAD mode and sweeps taps 0..TAP_MAX. At each tap it counts transitions across a chosen pair of adjacent samples in the 8-bit sample_window, then loads the tap with the fewest transitions. It sits between the IDELAYCTRL/PLL reset domain and the delay lines, in the clk_54 domain.

Parameters:
TAP_MAX, 31, last tap swept; the delay count is 5 bits.
SETTLE_CYCLES, 8, idle cycles after each LD before measuring.
WINDOW_CYCLES, 1024, measurement cycles per tap.
CNT_W, 11, edge-counter width; the counter saturates at 2^CNT_W-1.
CHK_HI, 4, upper sample index of the monitored pair.
CHK_LO, 3, lower sample index of the monitored pair; CHK_HI = CHK_LO+1.
ERR_THRESH, 64, a best_count above this value flags cal_err.

Ports:
clk  in  1  sample-domain clock (clk_54).
aresetn  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse that begins calibration.
idelayctrl_ready  in  1  IDELAYCTRL RDY; asynchronous, double-flopped internally.
sample_window  in  8  oversampled data window, one word per clk.
delay_ld  out  1  one-cycle LD strobe to IDELAYE2.
delay_cntvalue  out  5  CNTVALUEIN to IDELAYE2; held stable between strobes.
busy  out  1  high while a sweep or the final apply is in progress.
done  out  1  high after a successful or flagged calibration; cleared by start.
best_tap  out  5  selected tap.
best_count  out  CNT_W  edge count at best_tap.
cal_err  out  1  best_count > ERR_THRESH; valid when done=1.

Behaviour:
- Reset values: delay_ld=0, delay_cntvalue=0, busy=0, done=0, best_tap=0, best_count=all-ones, cal_err=0. The state machine resets to IDLE.
- rdy_s is idelayctrl_ready after a 2-flop synchronizer, so it lags the input by 2 cycles.
- State IDLE: on start, go to WAIT_RDY, set busy=1, clear done and cal_err, set best_count to all-ones, set tap=0.
- State WAIT_RDY: stay until rdy_s=1, then go to LOAD.
- State LOAD (1 cycle): delay_cntvalue=tap, delay_ld=1. Next state is SETTLE with a settle counter of 0.
- State SETTLE: count SETTLE_CYCLES cycles, then go to MEASURE with edge_cnt=0 and win_cnt=0.
- State MEASURE: on each cycle, edge_cnt increments (saturating) when sample_window[CHK_HI] != sample_window[CHK_LO]. After exactly WINDOW_CYCLES samples, go to COMPARE. The sample in the last cycle is counted.
- State COMPARE (1 cycle): if edge_cnt < best_count, update best_tap=tap and best_count=edge_cnt. Strict less-than means ties keep the lower tap. If tap==TAP_MAX go to APPLY; otherwise increment tap and go to LOAD.
- State APPLY (1 cycle): delay_cntvalue=best_tap, delay_ld=1, cal_err=(best_count>ERR_THRESH). Then go to DONE.
- State DONE: busy=0, done=1. A start pulse restarts the sweep exactly as from IDLE.
- start while busy=1 is ignored.
- If rdy_s falls in LOAD, SETTLE, MEASURE or COMPARE: abort to WAIT_RDY, reset tap to 0 and best_count to all-ones. The sweep restarts from tap 0 when ready returns.
- delay_ld is high only in LOAD and APPLY, for exactly one cycle each. delay_cntvalue changes only in the cycle delay_ld asserts and holds until the next strobe.
- Full-sweep latency from start to done, with rdy_s already high: 2 + (TAP_MAX+1)*(1+SETTLE_CYCLES+WINDOW_CYCLES+1) + 1 cycles.
- Asynchronous aresetn mid-sweep returns all outputs to their reset values immediately. The IDELAY keeps whatever tap it last loaded.

Decomposition:
- Package oversample_cal_pkg holds:
  - the state encoding (IDLE, WAIT_RDY, LOAD, SETTLE, MEASURE, COMPARE, APPLY, DONE);
  - TAP_W=5;
  - the default CNT_W.
- One sub-module, edge_counter_sat: compares the sample pair and keeps a saturating CNT_W counter with clear and enable. The main module holds the state machine, tap/best registers and synchronizer.

Test Plan:
1. Bench uses TAP_MAX=31, SETTLE=4, WINDOW=16. Bench model toggles the sample pair every cycle except at taps 12..15, where it never toggles. Pulse start -> 32 LD strobes with cntvalue 0..31, then an APPLY strobe with cntvalue=12, best_tap=12, best_count=0, done=1, cal_err=0.
2. Every tap produces 5 edges per window -> best_tap=0 (tie rule), best_count=5, done=1.
3. Pair toggles every cycle at all taps -> best_count=16, and cal_err=1 with ERR_THRESH=8.
4. Drop idelayctrl_ready for 3 cycles during MEASURE at tap 20 -> FSM returns to WAIT_RDY, next LD has cntvalue=0, and the final result matches scenario 1.
5. Pulse start while busy, then again after done -> the first is ignored; the second clears done within 1 cycle and re-sweeps.
6. Assert aresetn low mid-SETTLE -> all outputs go to reset values in the same cycle, and no delay_ld pulse occurs until the next start.
